// File: rtl/if_fetch_unit_pkg.sv
// Shared widths and helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int MXLEN     = 64;
  localparam int ILEN_DEF  = 32;
  localparam int DEPTH_DEF = 2;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Circular buffer of {pc, inst, filled} entries for the fetch stage.
// Entries are allocated at request time, filled in allocation order when
// the response arrives, and freed from the head when decode takes them.
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int XLEN  = MXLEN,
  parameter int ILEN  = ILEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [ILEN-1:0] fill_inst,
  input  logic            free,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   unfilled,
  output logic            head_filled,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_inst
);

  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [ILEN-1:0]  inst_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    nfilled;

  // Pointer, occupancy and filled-flag bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_ptr <= '0;
      count_q  <= '0;
      filled   <= '0;
    end else begin
      if (alloc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fill) begin
        fill_ptr         <= fill_ptr + PW'(1);
        filled[fill_ptr] <= 1'b1;
      end
      if (free) begin
        rd_ptr         <= rd_ptr + PW'(1);
        filled[rd_ptr] <= 1'b0;
      end
      count_q <= count_q + CW'(alloc) - CW'(free);
    end
  end

  // Entry payload storage; no reset needed since validity lives in the flags.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[wr_ptr] <= alloc_pc;
    end
    if (fill) begin
      inst_mem[fill_ptr] <= fill_inst;
    end
  end

  // Allocated entries still waiting for their memory response.
  always_comb begin
    nfilled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nfilled = nfilled + CW'(filled[i]);
    end
    unfilled = count_q - nfilled;
  end

  assign count       = count_q;
  assign head_filled = filled[rd_ptr];
  assign head_pc     = pc_mem[rd_ptr];
  assign head_inst   = inst_mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues in-order memory requests for the PC stage,
// buffers {pc, inst} pairs for decode and swallows responses that belong to
// fetches cancelled by a redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int XLEN  = MXLEN,
  parameter int ILEN  = ILEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_valid_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_ready_o,
  input  logic            flush_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [ILEN-1:0] id_inst_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]   q_count;
  logic [CW-1:0]   q_unfilled;
  logic [CW-1:0]   drop_cnt;
  logic            head_filled;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_inst;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            id_fire;

  // Request side: same-cycle handshake, gated by the registered occupancy so a
  // free in this cycle cannot open a slot until the next one.
  always_comb begin
    imem_req_valid_o = !rst && pc_valid_i && !flush_i && (q_count != FULL);
    imem_req_addr_o  = pc_i;
    pc_ready_o       = imem_req_valid_o && imem_req_ready_i;
  end

  // Response side: responses owed to cancelled fetches are consumed before any fill.
  always_comb begin
    rsp_drop = imem_rsp_valid_i && (drop_cnt != '0);
    rsp_fill = imem_rsp_valid_i && (drop_cnt == '0);
  end

  // Decode side: outputs read zero unless the head holds a fetched instruction.
  always_comb begin
    id_valid_o = !rst && head_filled;
    id_pc_o    = id_valid_o ? head_pc : '0;
    id_inst_o  = id_valid_o ? head_inst : '0;
    id_fire    = id_valid_o && id_ready_i;
  end

  // Count of responses still to be discarded; a redirect adds every fetch that
  // was allocated but not yet answered, less one answered in the redirect cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush_i) begin
      drop_cnt <= drop_cnt - CW'(rsp_drop) + q_unfilled - CW'(rsp_fill);
    end else begin
      drop_cnt <= drop_cnt - CW'(rsp_drop);
    end
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .clear       (flush_i),
    .alloc       (pc_ready_o),
    .alloc_pc    (pc_i),
    .fill        (rsp_fill),
    .fill_inst   (imem_rsp_data_i),
    .free        (id_fire),
    .count       (q_count),
    .unfilled    (q_unfilled),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_inst   (head_inst)
  );

  // A response with nothing allocated and nothing to drop means memory broke the protocol.
  assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid_i && (q_count == '0) && (drop_cnt == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes expected {pc, inst}
// pairs, a monitor pops and compares on every decode handshake.
module tb_if_fetch_unit;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            pc_valid_i;
  logic [XLEN-1:0] pc_i;
  logic            pc_ready_o;
  logic            flush_i;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i;
  logic [ILEN-1:0] imem_rsp_data_i;
  logic            id_valid_o;
  logic            id_ready_i;
  logic [XLEN-1:0] id_pc_o;
  logic [ILEN-1:0] id_inst_o;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } exp_t;

  exp_t            exp_q[$];
  logic [XLEN-1:0] pend[$];
  int              checks = 0;
  int              errors = 0;
  int              req_cnt = 0;
  bit              mem_hold = 1'b0;

  if_fetch_unit #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_valid_i       (pc_valid_i),
    .pc_i             (pc_i),
    .pc_ready_o       (pc_ready_o),
    .flush_i          (flush_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_inst_o        (id_inst_o)
  );

  always #5 clk = ~clk;

  // Memory contents: a recognisable word derived from the address.
  function automatic logic [ILEN-1:0] inst_of(input logic [XLEN-1:0] pc);
    return 32'hDEAD_0000 | {16'h0000, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present pc until accepted (bounded); optionally expect it at decode.
  task automatic issue(input logic [XLEN-1:0] pc, input bit deliver);
    bit done;
    done = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = pc;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (pc_ready_o) begin
        done = 1'b1;
        if (deliver) exp_q.push_back('{pc: pc, inst: inst_of(pc)});
      end
      @(posedge clk);
      #1;
    end
    pc_valid_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_accept: pc %0h never accepted, got no pc_ready_o, expected acceptance", pc);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain: got %0d outputs still expected, expected 0", exp_q.size());
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory request capture and decode-side scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid_o && imem_req_ready_i) begin
        pend.push_back(imem_req_addr_o);
        req_cnt++;
      end
      if (id_valid_o && id_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %0h inst %0h, expected no output", id_pc_o, id_inst_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("id_pc", id_pc_o, e.pc);
          chk("id_inst", 64'(id_inst_o), 64'(e.inst));
        end
      end
    end
  end

  // Memory model: in-order, one response per accepted request, earliest the next cycle.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      pend.delete();
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end else if (!mem_hold && pend.size() > 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = inst_of(pend.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_before;
    rst = 1'b1;
    pc_valid_i = 1'b1;
    pc_i = '0;
    flush_i = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    id_ready_i = 1'b1;

    // Reset held with a valid PC presented
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_valid", imem_req_valid_o, 0);
      chk("rst_pc_ready", pc_ready_o, 0);
      chk("rst_id_valid", id_valid_o, 0);
      chk("rst_id_pc", id_pc_o, 0);
      chk("rst_id_inst", 64'(id_inst_o), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First request after release, then streaming 0x0, 0x4, 0x8
    @(negedge clk);
    chk("first_req_valid", imem_req_valid_o, 1);
    chk("first_req_addr", imem_req_addr_o, 64'h0);
    chk("first_pc_ready", pc_ready_o, 1);
    exp_q.push_back('{pc: 64'h0, inst: inst_of(64'h0)});
    @(posedge clk);
    #1;
    pc_valid_i = 1'b0;
    fork
      issue(64'h4, 1'b1);
      begin
        @(negedge clk);
        chk("no_bypass_id_valid", id_valid_o, 0);
      end
    join
    issue(64'h8, 1'b1);
    wait_drain();

    // Decode backpressure: queue fills after two fetches, head held
    id_ready_i = 1'b0;
    issue(64'h0, 1'b1);
    issue(64'h4, 1'b1);
    pc_valid_i = 1'b1;
    pc_i = 64'h8;
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_valid", imem_req_valid_o, 0);
      chk("bp_pc_ready", pc_ready_o, 0);
      chk("bp_head_pc", id_pc_o, 64'h0);
      chk("bp_head_valid", id_valid_o, 1);
      @(posedge clk);
      #1;
    end
    id_ready_i = 1'b1;
    issue(64'h8, 1'b1);
    wait_drain();

    // Flush with two unanswered fetches in flight
    mem_hold = 1'b1;
    issue(64'h200, 1'b0);
    issue(64'h204, 1'b0);
    flush_i = 1'b1;
    pc_valid_i = 1'b1;
    pc_i = 64'h104;
    @(negedge clk);
    chk("flush_req_valid", imem_req_valid_o, 0);
    chk("flush_id_valid", id_valid_o, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    mem_hold = 1'b0;
    fork
      issue(64'h100, 1'b1);
      begin
        @(negedge clk);
        chk("drop1_id_valid", id_valid_o, 0);
      end
    join
    @(negedge clk);
    chk("drop2_id_valid", id_valid_o, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("refill_id_valid", id_valid_o, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_flush_id_valid", id_valid_o, 1);
    chk("post_flush_id_pc", id_pc_o, 64'h100);
    wait_drain();

    // Flush coincident with a response
    mem_hold = 1'b1;
    issue(64'h300, 1'b0);
    issue(64'h304, 1'b0);
    mem_hold = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    chk("cflush_id_valid", id_valid_o, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    fork
      issue(64'h108, 1'b1);
      begin
        @(negedge clk);
        chk("cdrop_id_valid", id_valid_o, 0);
      end
    join
    @(negedge clk);
    chk("cfill_id_valid", id_valid_o, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cpost_id_valid", id_valid_o, 1);
    chk("cpost_id_pc", id_pc_o, 64'h108);
    chk("cpost_id_inst", 64'(id_inst_o), 64'hDEAD_0108);
    wait_drain();

    // Memory stall: pc held, fetched exactly once
    imem_req_ready_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 64'h400;
    req_before = req_cnt;
    repeat (4) begin
      @(negedge clk);
      chk("stall_pc_ready", pc_ready_o, 0);
      chk("stall_req_valid", imem_req_valid_o, 1);
      chk("stall_req_addr", imem_req_addr_o, 64'h400);
      @(posedge clk);
      #1;
    end
    imem_req_ready_i = 1'b1;
    issue(64'h400, 1'b1);
    wait_drain();
    chk("stall_req_count", 64'(req_cnt - req_before), 1);

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
